multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Moore main-control state machine for the multicycle RISC-V core.
- Sequences the shared ALU, instruction/data memory port, register file and PC through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp consumed by the ALU decoder: 00 add, 01 branch compare, 10 funct-decoded, 11 LUI.
- Sits between the instruction register (opcode field) and the datapath multiplexers and enables.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for MemReady; 0 = MemReady ignored and treated as 1.
- TRAP_ON_ILLEGAL, 1: 1 = unknown opcode enters TRAP; 0 = unknown opcode returns to FETCH as a no-op.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  7  instruction opcode, Instr[6:0]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory access complete this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  output  2  ALU operand B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  to ALU decoder
- ImmSrc  output  3  immediate format select
- RegWrite  output  1  register file write enable
- Illegal  output  1  sticky illegal-opcode flag
- State  output  4  current state, for debug

Behaviour:
- Reset is asynchronous, active-low: state = FETCH (0), Illegal = 0.
- While rst_n = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
- State encoding:
  FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, LUI 11, AUIPC 12, TRAP 13.
  Codes 14 and 15 go to FETCH on the next edge.
- Unlisted outputs in any state are 0. Outputs are a function of state only, except:
  - the MemReady gating described below;
  - ImmSrc, which is decoded from op.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCWrite = MemReady. Go to DECODE if MemReady, else stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - other -> TRAP (or FETCH when TRAP_ON_ILLEGAL = 0)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op = 0000011, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held asserted every cycle until MemReady. Go to FETCH on MemReady.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - LUI: ALUSrcB=01, ALUOp=11. Go to ALUWB.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Go to ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB (writes PC+4 to rd).
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite = Zero. Go to FETCH.
  - TRAP: all enables 0, Illegal=1. Stays in TRAP until reset. Illegal is set on entry and stays set until reset.
- ImmSrc from op:
  - 000 for 0000011 and 0010011
  - 001 for 0100011
  - 010 for 1100011
  - 011 for 1101111
  - 100 for 0110111 and 0010111
  - 000 otherwise
- Instruction latency in cycles, with zero memory wait: lw 5, sw 4, R/I/LUI/AUIPC 4, jal 4, beq 3. Each wait cycle on MemReady in FETCH, MEMREAD or MEMWRITE adds exactly 1.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
- Reset asserted mid-instruction: state goes to FETCH immediately and no write strobe is emitted during or after the asserting edge.

Test Plan:
- Reset then add (op=0110011), MemReady=1 -> states 0,1,6,7,0; ALUOp=10 in EXECR; RegWrite=1 only in ALUWB; 4 cycles total.
- lw (op=0000011) with MemReady low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles; AdrSrc=1 throughout; RegWrite=1 with ResultSrc=01 in MEMWB; ImmSrc=000.
- beq with Zero=1, then again with Zero=0 -> PCWrite=1 in BEQ for the first and 0 for the second; ALUOp=01; ImmSrc=010; returns to FETCH after 3 cycles.
- lui (0110111) and jal (1101111) -> ALUOp=11 in LUI; jal asserts PCWrite in JAL with ALUSrcA=01, ALUSrcB=10, then RegWrite in ALUWB.
- op=1111111 in DECODE -> TRAP (13), Illegal=1, all enables stay 0 for 10+ cycles; rst_n low -> State=0, Illegal=0. With TRAP_ON_ILLEGAL=0 -> back to FETCH, Illegal stays 0.
- sw with MemReady=0 in MEMWRITE and rst_n pulsed low -> MemWrite drops to 0 asynchronously, State=0; no PCWrite, IRWrite or RegWrite while reset is asserted.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath selects and enables.
module multicycle_main_fsm #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    LUI      = 4'd11,
    AUIPC    = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_q;
  logic   illegal_q;
  logic   mem_ready;
  logic   pc_write, ir_write, mem_write, reg_write;

  assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:    state_q <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state_q <= MEMADR;
            OP_RTYPE:          state_q <= EXECR;
            OP_ITYPE:          state_q <= EXECI;
            OP_BRANCH:         state_q <= BEQ;
            OP_JAL:            state_q <= JAL;
            OP_LUI:            state_q <= LUI;
            OP_AUIPC:          state_q <= AUIPC;
            default: begin
              if (TRAP_ON_ILLEGAL) begin
                state_q   <= TRAP;
                illegal_q <= 1'b1;
              end else begin
                state_q <= FETCH;
              end
            end
          endcase
        end
        MEMADR:   state_q <= (op == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:  state_q <= mem_ready ? MEMWB : MEMREAD;
        MEMWB:    state_q <= FETCH;
        MEMWRITE: state_q <= mem_ready ? FETCH : MEMWRITE;
        EXECR, EXECI, LUI, AUIPC, JAL: state_q <= ALUWB;
        ALUWB, BEQ: state_q <= FETCH;
        TRAP:     state_q <= TRAP;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      LUI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        pc_write = Zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:        ImmSrc = 3'b001;
      OP_BRANCH:       ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:         ImmSrc = 3'b000;
    endcase
  end

  // Write strobes are gated by rst_n so a reset landing mid-instruction
  // (e.g. during a stalled store) kills them without waiting for an edge.
  assign PCWrite  = pc_write  & rst_n;
  assign IRWrite  = ir_write  & rst_n;
  assign MemWrite = mem_write & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign Illegal  = illegal_q;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: a per-cycle vector table plus
// hand-written reset, trap and parameter-variant sequences.
module tb_multicycle_main_fsm;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6,  S_ALUWB = 4'd7,  S_EXECI = 4'd8,
                         S_JAL = 4'd9,    S_BEQ = 4'd10,   S_LUI = 4'd11,
                         S_AUIPC = 4'd12, S_TRAP = 4'd13;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic [2:0] imm;
    logic       rw;
    logic       ill;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic zero, mem_ready;

  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state;

  logic pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal2;
  logic [1:0] result_src2, alu_src_a2, alu_src_b2, alu_op2;
  logic [2:0] imm_src2;
  logic [3:0] state2;

  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write),
    .IRWrite(ir_write), .ResultSrc(result_src), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .ALUOp(alu_op), .ImmSrc(imm_src),
    .RegWrite(reg_write), .Illegal(illegal), .State(state)
  );

  multicycle_main_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pc_write2), .AdrSrc(adr_src2), .MemWrite(mem_write2),
    .IRWrite(ir_write2), .ResultSrc(result_src2), .ALUSrcA(alu_src_a2),
    .ALUSrcB(alu_src_b2), .ALUOp(alu_op2), .ImmSrc(imm_src2),
    .RegWrite(reg_write2), .Illegal(illegal2), .State(state2)
  );

  function automatic out_t o(input logic [3:0] st, input logic pcw,
                             input logic adr, input logic mw, input logic irw,
                             input logic [1:0] rs, input logic [1:0] sa,
                             input logic [1:0] sb, input logic [1:0] aop,
                             input logic [2:0] imm, input logic rw,
                             input logic ill);
    out_t r;
    r = '{st, pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill};
    return r;
  endfunction

  function automatic out_t f_fetch(input logic en, input logic [2:0] imm);
    return o(S_FETCH, en, 1'b0, 1'b0, en, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0, 1'b0);
  endfunction

  function automatic out_t f_decode(input logic [2:0] imm);
    return o(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, 1'b0);
  endfunction

  function automatic out_t f_aluwb(input logic [2:0] imm);
    return o(S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0);
  endfunction

  function automatic out_t f_memadr(input logic [2:0] imm);
    return o(S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0);
  endfunction

  function automatic vec_t v(input logic rst, input logic [6:0] opc,
                             input logic z, input logic rdy, input out_t e);
    vec_t r;
    r.rst = rst; r.op = opc; r.zero = z; r.rdy = rdy; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               name, act.st, act, exp.st, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, queue the expectation,
  // then compare the combinational outputs well before the next rising edge.
  task automatic step(input string name, input vec_t vv, input bit use2);
    out_t act;
    out_t exp;
    @(negedge clk);
    rst_n = vv.rst; op = vv.op; zero = vv.zero; mem_ready = vv.rdy;
    exp_q.push_back(vv.exp);
    #2;
    if (use2)
      act = {state2, pc_write2, adr_src2, mem_write2, ir_write2, result_src2,
             alu_src_a2, alu_src_b2, alu_op2, imm_src2, reg_write2, illegal2};
    else
      act = {state, pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal};
    exp = exp_q.pop_front();
    check(name, act, exp);
  endtask

  initial begin
    rst_n = 1'b0; op = OP_R; zero = 1'b0; mem_ready = 1'b1;

    // Reset row: strobes forced low even though MemReady is high.
    tbl.push_back(v(0, OP_R, 0, 1, f_fetch(0, 3'b000)));
    // add; op changed after DECODE must have no effect
    tbl.push_back(v(1, OP_R, 0, 1, f_fetch(1, 3'b000)));
    tbl.push_back(v(1, OP_R, 0, 1, f_decode(3'b000)));
    tbl.push_back(v(1, OP_BAD, 0, 1, o(S_EXECR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0)));
    tbl.push_back(v(1, OP_BAD, 0, 1, f_aluwb(3'b000)));
    // lw with one FETCH wait and two MEMREAD waits
    tbl.push_back(v(1, OP_LW, 0, 0, f_fetch(0, 3'b000)));
    tbl.push_back(v(1, OP_LW, 0, 1, f_fetch(1, 3'b000)));
    tbl.push_back(v(1, OP_LW, 0, 1, f_decode(3'b000)));
    tbl.push_back(v(1, OP_LW, 0, 1, f_memadr(3'b000)));
    tbl.push_back(v(1, OP_LW, 0, 0, o(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0)));
    tbl.push_back(v(1, OP_LW, 0, 0, o(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0)));
    tbl.push_back(v(1, OP_LW, 0, 1, o(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0)));
    tbl.push_back(v(1, OP_LW, 0, 0, o(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0)));
    // beq taken, then not taken
    tbl.push_back(v(1, OP_BEQ, 1, 1, f_fetch(1, 3'b010)));
    tbl.push_back(v(1, OP_BEQ, 1, 1, f_decode(3'b010)));
    tbl.push_back(v(1, OP_BEQ, 1, 1, o(S_BEQ, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0, 0)));
    tbl.push_back(v(1, OP_BEQ, 0, 1, f_fetch(1, 3'b010)));
    tbl.push_back(v(1, OP_BEQ, 0, 1, f_decode(3'b010)));
    tbl.push_back(v(1, OP_BEQ, 0, 1, o(S_BEQ, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0, 0)));
    // lui
    tbl.push_back(v(1, OP_LUI, 0, 1, f_fetch(1, 3'b100)));
    tbl.push_back(v(1, OP_LUI, 0, 1, f_decode(3'b100)));
    tbl.push_back(v(1, OP_LUI, 0, 1, o(S_LUI, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11, 3'b100, 0, 0)));
    tbl.push_back(v(1, OP_LUI, 0, 1, f_aluwb(3'b100)));
    // jal
    tbl.push_back(v(1, OP_JAL, 0, 1, f_fetch(1, 3'b011)));
    tbl.push_back(v(1, OP_JAL, 0, 1, f_decode(3'b011)));
    tbl.push_back(v(1, OP_JAL, 0, 1, o(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 0, 0)));
    tbl.push_back(v(1, OP_JAL, 0, 1, f_aluwb(3'b011)));
    // sw with one MEMWRITE wait
    tbl.push_back(v(1, OP_SW, 0, 1, f_fetch(1, 3'b001)));
    tbl.push_back(v(1, OP_SW, 0, 1, f_decode(3'b001)));
    tbl.push_back(v(1, OP_SW, 0, 1, f_memadr(3'b001)));
    tbl.push_back(v(1, OP_SW, 0, 0, o(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0)));
    tbl.push_back(v(1, OP_SW, 0, 1, o(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0)));
    // auipc
    tbl.push_back(v(1, OP_AUIPC, 0, 1, f_fetch(1, 3'b100)));
    tbl.push_back(v(1, OP_AUIPC, 0, 1, f_decode(3'b100)));
    tbl.push_back(v(1, OP_AUIPC, 0, 1, o(S_AUIPC, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100, 0, 0)));
    tbl.push_back(v(1, OP_AUIPC, 0, 1, f_aluwb(3'b100)));
    // addi
    tbl.push_back(v(1, OP_I, 0, 1, f_fetch(1, 3'b000)));
    tbl.push_back(v(1, OP_I, 0, 1, f_decode(3'b000)));
    tbl.push_back(v(1, OP_I, 0, 1, o(S_EXECI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 0, 0)));
    tbl.push_back(v(1, OP_I, 0, 1, f_aluwb(3'b000)));

    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i], 1'b0);

    // Stalled store interrupted by reset: MemWrite and all strobes must drop.
    step("sw_fetch", v(1, OP_SW, 0, 1, f_fetch(1, 3'b001)), 1'b0);
    step("sw_decode", v(1, OP_SW, 0, 1, f_decode(3'b001)), 1'b0);
    step("sw_memadr", v(1, OP_SW, 0, 1, f_memadr(3'b001)), 1'b0);
    step("sw_stall", v(1, OP_SW, 0, 0,
         o(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0)), 1'b0);
    step("sw_rst_async", v(0, OP_SW, 1, 1, f_fetch(0, 3'b001)), 1'b0);
    step("sw_rst_held", v(0, OP_SW, 1, 1, f_fetch(0, 3'b001)), 1'b0);
    step("sw_after_rst", v(1, OP_SW, 0, 0, f_fetch(0, 3'b001)), 1'b0);

    // Illegal opcode: TRAP is sticky with every enable low.
    step("bad_fetch", v(1, OP_BAD, 0, 1, f_fetch(1, 3'b000)), 1'b0);
    step("bad_decode", v(1, OP_BAD, 0, 1, f_decode(3'b000)), 1'b0);
    for (int i = 0; i < 12; i++)
      step($sformatf("trap%0d", i), v(1, OP_BAD, 1, 1,
           o(S_TRAP, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1)), 1'b0);
    step("trap_rst", v(0, OP_BAD, 0, 1, f_fetch(0, 3'b000)), 1'b0);
    step("trap_rst_held", v(0, OP_BAD, 0, 1, f_fetch(0, 3'b000)), 1'b0);

    // No-trap, no-handshake variant: MemReady ignored, illegal op is a no-op.
    step("v2_fetch", v(1, OP_BAD, 0, 0, f_fetch(1, 3'b000)), 1'b1);
    step("v2_decode", v(1, OP_BAD, 0, 0, f_decode(3'b000)), 1'b1);
    step("v2_lw_fetch", v(1, OP_LW, 0, 0, f_fetch(1, 3'b000)), 1'b1);
    step("v2_lw_decode", v(1, OP_LW, 0, 0, f_decode(3'b000)), 1'b1);
    step("v2_lw_memadr", v(1, OP_LW, 0, 0, f_memadr(3'b000)), 1'b1);
    step("v2_lw_memread", v(1, OP_LW, 0, 0,
         o(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0)), 1'b1);
    step("v2_lw_memwb", v(1, OP_LW, 0, 0,
         o(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0)), 1'b1);
    step("v2_back_fetch", v(1, OP_LW, 0, 0, f_fetch(1, 3'b000)), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
